// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state enums plus flag bit positions for seq_alu
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ADC = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_INC = 4'd8,
        OP_DEC = 4'd9,
        OP_SHL = 4'd10,
        OP_SHR = 4'd11,
        OP_ASR = 4'd12,
        OP_ROL = 4'd13,
        OP_ROR = 4'd14,
        OP_MUL = 4'd15
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result handshake bundle between a requester and seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       nzvc;

    modport master (
        output in_valid, op, a, b, carry_in, out_ready,
        input  in_ready, out_valid, result, result_hi, nzvc
    );

    modport slave (
        input  in_valid, op, a, b, carry_in, out_ready,
        output in_ready, out_valid, result, result_hi, nzvc
    );
endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               running;

    // Always runs all WIDTH iterations so latency does not depend on operand values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            acc     <= '0;
            mplier  <= b;
            count   <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            if (count != '0) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    assign done    = running && (count == '0);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with handshake; iterative MUL built only when SEQ_ALU_MUL_EN is defined
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    state_t           state;
    op_t              op_c;
    logic             transfer;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic [3:0]       flags;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [3:0]       nzvc_q;

    assign op_c     = op_t'(bus.op);
    assign transfer = bus.in_valid && bus.in_ready;

    always_comb begin
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op_c)
            OP_ADD: begin
                sum = {1'b0, bus.a} + {1'b0, bus.b};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.a[MSB] == bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            end
            OP_ADC: begin
                sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.carry_in};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.a[MSB] == bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            end
            // Bit WIDTH of the widened difference is the borrow.
            OP_SUB: begin
                sum = {1'b0, bus.a} - {1'b0, bus.b};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.a[MSB] != bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            end
            OP_SBC: begin
                sum = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.carry_in};
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = (bus.a[MSB] != bus.b[MSB]) && (r[MSB] != bus.a[MSB]);
            end
            OP_AND: r = bus.a & bus.b;
            OP_OR:  r = bus.a | bus.b;
            OP_XOR: r = bus.a ^ bus.b;
            OP_NOT: r = ~bus.a;
            OP_INC: begin
                sum = {1'b0, bus.a} + (WIDTH+1)'(1);
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = !bus.a[MSB] && r[MSB];
            end
            OP_DEC: begin
                sum = {1'b0, bus.a} - (WIDTH+1)'(1);
                r   = sum[MSB:0];
                c   = sum[WIDTH];
                v   = bus.a[MSB] && !r[MSB];
            end
            OP_SHL: begin
                r = bus.a << 1;
                c = bus.a[MSB];
            end
            OP_SHR: begin
                r = bus.a >> 1;
                c = bus.a[0];
            end
            OP_ASR: begin
                r = {bus.a[MSB], bus.a[MSB:1]};
                c = bus.a[0];
            end
            OP_ROL: begin
                r = {bus.a[MSB-1:0], bus.a[MSB]};
                c = bus.a[MSB];
            end
            OP_ROR: begin
                r = {bus.a[0], bus.a[MSB:1]};
                c = bus.a[0];
            end
            OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                r = '0;
`else
                // Without a multiplier, opcode 15 reports Z and V together as an illegal-op marker.
                r = '0;
                v = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = r[MSB];
        flags[FLAG_Z] = (r == '0);
        flags[FLAG_V] = v;
        flags[FLAG_C] = c;
    end

`ifdef SEQ_ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [3:0]         mul_flags;

    assign mul_start = transfer && (op_c == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = product[2*WIDTH-1];
        mul_flags[FLAG_Z] = (product == '0);
        mul_flags[FLAG_V] = (product[2*WIDTH-1:WIDTH] != '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            nzvc_q      <= '0;
        end else if (transfer) begin
`ifdef SEQ_ALU_MUL_EN
            if (op_c == OP_MUL) begin
                state <= ST_BUSY;
            end else
`endif
            begin
                state       <= ST_DONE;
                result_q    <= r;
                result_hi_q <= '0;
                nzvc_q      <= flags;
            end
        end else begin
            case (state)
`ifdef SEQ_ALU_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state       <= ST_DONE;
                        result_q    <= product[WIDTH-1:0];
                        result_hi_q <= product[2*WIDTH-1:WIDTH];
                        nzvc_q      <= mul_flags;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.nzvc      = nzvc_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=8), MUL paths follow SEQ_ALU_MUL_EN
module tb_seq_alu;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic ci,
                          input logic [7:0] er, input logic [3:0] ef);
        @(negedge clk);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.carry_in = ci;
        bus.in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".result"}, bus.result, er);
        check({tag, ".result_hi"}, bus.result_hi, 0);
        check({tag, ".nzvc"}, bus.nzvc, ef);
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic mul_run(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] ehi, input logic [7:0] elo, input logic [3:0] ef);
        @(negedge clk);
        bus.op       = 4'd15;
        bus.a        = x;
        bus.b        = y;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            check({tag, ".busy_out_valid"}, bus.out_valid, 0);
            check({tag, ".busy_in_ready"}, bus.in_ready, 0);
            @(negedge clk);
        end
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".result_hi"}, bus.result_hi, ehi);
        check({tag, ".result"}, bus.result, elo);
        check({tag, ".nzvc"}, bus.nzvc, ef);
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.result", bus.result, 0);
        check("rst.result_hi", bus.result_hi, 0);
        check("rst.nzvc", bus.nzvc, 0);
        rst_n = 1'b1;

        run_op("add_wrap", 4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101);
        run_op("sub_ovf",  4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b0010);
        run_op("sbc_brw",  4'd3,  8'h00, 8'h00, 1'b1, 8'hFF, 4'b1001);
        run_op("adc_ovf",  4'd2,  8'h7F, 8'h00, 1'b1, 8'h80, 4'b1010);
        run_op("and",      4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000);
        run_op("or_zero",  4'd5,  8'h00, 8'h00, 1'b0, 8'h00, 4'b0100);
        run_op("xor",      4'd6,  8'hA5, 8'hFF, 1'b0, 8'h5A, 4'b0000);
        run_op("not",      4'd7,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b1000);
        run_op("inc_max",  4'd8,  8'h7F, 8'h00, 1'b0, 8'h80, 4'b1010);
        run_op("dec_zero", 4'd9,  8'h00, 8'h00, 1'b0, 8'hFF, 4'b1001);
        run_op("shl",      4'd10, 8'h80, 8'h00, 1'b0, 8'h00, 4'b0101);
        run_op("shr",      4'd11, 8'h01, 8'h00, 1'b0, 8'h00, 4'b0101);
        run_op("asr",      4'd12, 8'h81, 8'h00, 1'b0, 8'hC0, 4'b1001);
        run_op("rol",      4'd13, 8'h80, 8'h00, 1'b0, 8'h01, 4'b0001);
        run_op("ror",      4'd14, 8'h01, 8'h00, 1'b0, 8'h80, 4'b1001);

`ifdef SEQ_ALU_MUL_EN
        mul_run("mul_max",  8'hFF, 8'hFF, 8'hFE, 8'h01, 4'b1010);
        mul_run("mul_zero", 8'h00, 8'hA5, 8'h00, 8'h00, 4'b0100);
        mul_run("mul_small", 8'h0C, 8'h0B, 8'h00, 8'h84, 4'b0000);
`else
        run_op("mul_off",  4'd15, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0110);
`endif

        // back-pressure: result must hold while out_ready is low
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.op        = 4'd6;
        bus.a         = 8'hA5;
        bus.b         = 8'hFF;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.out_valid", bus.out_valid, 1);
        check("bp.result", bus.result, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.hold_valid", bus.out_valid, 1);
            check("bp.hold_result", bus.result, 8'h5A);
            check("bp.hold_nzvc", bus.nzvc, 4'b0000);
            check("bp.hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        bus.op        = 4'd0;
        bus.a         = 8'h01;
        bus.b         = 8'h02;
        bus.in_valid  = 1'b1;
        #1;
        check("bp.release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp.next_valid", bus.out_valid, 1);
        check("bp.next_result", bus.result, 8'h03);
        check("bp.next_nzvc", bus.nzvc, 4'b0000);
        @(negedge clk);
        check("bp.drain_valid", bus.out_valid, 0);

`ifdef SEQ_ALU_MUL_EN
        bus.op       = 4'd15;
        bus.a        = 8'h03;
        bus.b        = 8'h05;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
`else
        bus.out_ready = 1'b0;
        bus.op        = 4'd6;
        bus.a         = 8'h0F;
        bus.b         = 8'h00;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rstmid.pre_valid", bus.out_valid, 1);
        rst_n = 1'b0;
`endif
        @(negedge clk);
        check("rstmid.out_valid", bus.out_valid, 0);
        check("rstmid.in_ready", bus.in_ready, 1);
        check("rstmid.result", bus.result, 0);
        check("rstmid.result_hi", bus.result_hi, 0);
        check("rstmid.nzvc", bus.nzvc, 0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rstmid.idle_valid", bus.out_valid, 0);
        run_op("add_after_rst", 4'd0, 8'h02, 8'h03, 1'b0, 8'h05, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port op  input  4  opcode per alu_pkg.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port carry_in  input  1  carry/borrow for ADC/SBC.
REQ-009 SHALL have port out_valid  output  1  result held valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports result, result_hi  output  WIDTH  low/high result (result_hi nonzero only for MUL).
REQ-012 SHALL have port nzvc  output  4  flags [N,Z,V,C], registered with result.

Function
REQ-013 Opcodes: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT(a), 8 INC(a), 9 DEC(a), 10 SHL, 11 SHR, 12 ASR, 13 ROL, 14 ROR, 15 MUL (unsigned).
REQ-014 Transfer occurs when in_valid && in_ready; operands, op and carry_in SHALL be captured at that edge.
REQ-015 FSM states IDLE, BUSY, DONE: IDLE->DONE on transfer of opcode 0-14; IDLE->BUSY on transfer of MUL; BUSY->DONE after WIDTH iteration cycles; DONE->IDLE on out_ready without new transfer; DONE->DONE/BUSY on out_ready with simultaneous transfer.
REQ-016 in_ready SHALL be 1 in IDLE, or in DONE while out_ready=1; 0 in BUSY.
REQ-017 out_valid SHALL be 1 exactly in DONE; result, result_hi, nzvc SHALL stay stable until out_ready.
REQ-018 Latency: opcodes 0-14 out_valid one cycle after transfer; MUL WIDTH+1 cycles after transfer.
REQ-019 Arithmetic in WIDTH+1 bits; C = bit WIDTH for ADD/ADC/INC; C = borrow (1 when minuend < subtrahend[+carry_in]) for SUB/SBC/DEC.
REQ-020 V = signed two's-complement overflow for ADD/ADC/SUB/SBC/INC/DEC; V=0 for all others.
REQ-021 Logic ops and NOT: C=0, V=0; N, Z from result.
REQ-022 Shifts/rotates by one position; C = bit shifted out; ASR replicates MSB; ROL/ROR rotate through WIDTH bits only (not through C).
REQ-023 N = result MSB for opcodes 0-14; Z = (result==0); result_hi = 0 for opcodes 0-14.
REQ-024 MUL: {result_hi,result} = a*b, 2*WIDTH bits; N = result_hi MSB; Z = full product zero; V = (result_hi != 0); C=0.
REQ-025 Boundaries: ADD all-ones+1 -> result 0, Z=1, C=1; INC of max-positive -> V=1; DEC of 0 -> all-ones, C=1; MUL by 0 -> Z=1 after full WIDTH cycles (no early exit).

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE, out_valid=0, result=0, result_hi=0, nzvc=0, iteration counter=0; in_ready=1 combinationally from the reset state.
REQ-027 Reset during BUSY or DONE SHALL discard the operation with no output produced.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN: when defined, MUL behaves per REQ-024; when undefined, BUSY state and multiplier are not built, opcode 15 completes in one cycle with result=0, result_hi=0, nzvc=4'b0110 (Z and V set as illegal-op marker).

Structure
REQ-029 alu_pkg SHALL hold opcode enum, FSM state enum, flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0).
REQ-030 Iterative shift-add multiplier SHALL be sub-module alu_mul_iter (start, done, WIDTH parameter), instantiated only under SEQ_ALU_MUL_EN.
REQ-031 Single-cycle opcodes SHALL be computed combinationally from captured operands and registered into the output stage.

Verification (WIDTH=8)
REQ-032 ADD a=8'hFF b=8'h01, out_ready=1 -> next cycle out_valid=1, result=8'h00, nzvc=4'b0101.
REQ-033 SUB a=8'h80 b=8'h01 -> result=8'h7F, nzvc=4'b0010; SBC a=8'h00 b=8'h00 carry_in=1 -> result=8'hFF, nzvc=4'b1001.
REQ-034 MUL a=8'hFF b=8'hFF -> out_valid exactly 9 cycles after transfer, result_hi=8'hFE, result=8'h01, nzvc=4'b1010; in_ready=0 throughout BUSY.
REQ-035 ASR a=8'h81 -> result=8'hC0, nzvc=4'b1001; ROR a=8'h01 -> result=8'h80, nzvc=4'b1001.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles after XOR result -> outputs stable, in_ready=0; raise out_ready with in_valid=1 -> new transfer same cycle, next result following cycle.
REQ-037 Assert rst_n=0 in 4th BUSY cycle of MUL -> next cycle IDLE, out_valid=0, all outputs 0; subsequent ADD completes normally.
